data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

Two-port round-robin arbiter and sequencer for the LC3 data memory bus. It accepts load/store requests from two requesters: r0, the core memory-access stage, and r1, the debug/DMA port. It serialises them onto the single data memory interface (Data_addr, Data_din, Data_rd, D_macc, complete_data, Data_dout) and returns read data and completion to the granted requester. It sits between the LC3 core and the data memory model that the data_memory responder agent drives.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- TIMEOUT_CYCLES, 15, max ACCESS cycles before abort (used only with DATA_MEMORY_ARB_TIMEOUT_EN)
- clock  input  1  single system clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- rN_req  input  1  request from requester N (N=0,1); held until rN_gnt
- rN_rd  input  1  1 = load, 0 = store
- rN_addr  input  ADDR_W  access address
- rN_din  input  DATA_W  store data
- rN_gnt  output  1  one-cycle pulse; request fields sampled this cycle
- rN_done  output  1  one-cycle completion pulse
- rN_dout  output  DATA_W  load data; valid with rN_done, held until next done to N
- err  output  1  high with rN_done when access aborted by timeout
- Data_addr  output  ADDR_W  registered memory address
- Data_din  output  DATA_W  registered store data
- Data_rd  output  1  registered read/write select
- D_macc  output  1  memory access strobe, held high for the whole access
- complete_data  input  1  memory completion; sampled only while D_macc=1
- Data_dout  input  DATA_W  memory read data; valid when complete_data=1

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any rN_req is high, select a winner and pulse its rN_gnt.
  - Register its rd/addr/din onto Data_rd/Data_addr/Data_din and set D_macc=1.
  - Go to ACCESS.
- ACCESS: hold D_macc and the bus fields stable. When complete_data=1:
  - clear D_macc;
  - if Data_rd=1, capture Data_dout into the winner's rN_dout;
  - go to RESP.
- RESP: pulse the winner's rN_done for one cycle; return to IDLE.
- Arbitration is round-robin on a 1-bit last-grant pointer.
  - If both request, grant the one not granted last.
  - A single requester always wins.
  - After reset the pointer favours r0.
- Stores leave rN_dout unchanged.
- complete_data while D_macc=0 is ignored. A new rN_req during ACCESS/RESP waits.
- Reset, including mid-access:
  - all outputs go to 0, rN_dout clears to 0, state returns to IDLE, pointer resets to r0;
  - any in-flight access is dropped with no rN_done.

## Timing
- Request seen in IDLE at cycle t: rN_gnt=1 at t, and D_macc/Data_* are valid from t+1.
- complete_data is allowed at t+1 (zero-wait memory).
- complete_data at cycle c: D_macc=0 at c+1, rN_done=1 and rN_dout valid at c+1, IDLE at c+2.
- Minimum access occupancy is 3 cycles. The earliest next grant is at c+2.
- Bus fields never change while D_macc=1.

## Configuration
- DATA_MEMORY_ARB_TIMEOUT_EN defined:
  - a 4-bit+ counter runs in ACCESS;
  - if TIMEOUT_CYCLES cycles pass without complete_data, clear D_macc, go to RESP, and pulse rN_done with err=1;
  - for a load, rN_dout is set to 0.
- Undefined: no counter; ACCESS waits indefinitely; err tied to 0.

## Structure
- Package data_memory_arb_pkg holds:
  - the state enum typedef (IDLE/ACCESS/RESP);
  - ADDR_W/DATA_W defaults;
  - the TIMEOUT_CYCLES default.
- One sub-module, rr_arbiter_2: combinational winner select plus the registered last-grant pointer, updated on grant.

## Test plan
- r0 load, addr 16'h3000, memory returns 16'hBEEF with complete_data 2 cycles after D_macc -> r0_done once, r0_dout=16'hBEEF, Data_rd=1 held for 3 cycles.
- r1 store, addr 16'h4010, din 16'h1234 -> Data_rd=0, Data_din=16'h1234 stable until complete_data; r1_done pulses; r1_dout unchanged.
- r0 and r1 request together continuously -> grants alternate r0, r1, r0, r1; no back-to-back grant to the same requester.
- Reset asserted during ACCESS -> next cycle D_macc=0, all dout cleared, no done; a later r1-only request is granted normally.
- Zero-wait memory with complete_data at the first D_macc cycle -> done 1 cycle later, 3-cycle throughput.
- With DATA_MEMORY_ARB_TIMEOUT_EN, complete_data never asserted -> after 15 ACCESS cycles rN_done=1 with err=1 and rN_dout=0. Without the macro, D_macc stays high.

Source files
------------

// File: rtl/data_memory_arb_pkg.sv
// Shared types and default sizing for the data memory arbiter.
package data_memory_arb_pkg;

    localparam int unsigned AddrWDef         = 16;
    localparam int unsigned DataWDef         = 16;
    localparam int unsigned TimeoutCyclesDef = 15;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin winner select with a registered last-grant pointer.
module rr_arbiter_2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       grant_i,
    output logic       winner_o,
    output logic       valid_o
);

    logic last_q, last_d;

    always_comb begin
        valid_o = |req_i;
        if (req_i == 2'b11) begin
            winner_o = ~last_q;
        end else begin
            winner_o = req_i[1];
        end
        last_d = grant_i ? winner_o : last_q;
    end

    // Reset to "r1 granted last" so r0 wins the first contested round.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Serialises two requesters onto the LC3 data memory bus (IDLE/ACCESS/RESP sequencer).
// Optional access timeout enabled by defining DATA_MEMORY_ARB_TIMEOUT_EN.
module data_memory_arbiter
    import data_memory_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = AddrWDef,
    parameter int unsigned DATA_W         = DataWDef,
    parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDef
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_rd,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_din,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_dout,
    input  logic              r1_req,
    input  logic              r1_rd,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_din,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_dout,
    output logic              err,
    output logic [ADDR_W-1:0] Data_addr,
    output logic [DATA_W-1:0] Data_din,
    output logic              Data_rd,
    output logic              D_macc,
    input  logic              complete_data,
    input  logic [DATA_W-1:0] Data_dout
);

    arb_state_e        state_q, state_d;
    logic              winner_q, winner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              rd_q, rd_d;
    logic              macc_q, macc_d;
    logic [DATA_W-1:0] dout0_q, dout0_d;
    logic [DATA_W-1:0] dout1_q, dout1_d;
    logic              arb_winner, arb_valid, grant;

    // Gate grants during reset so no requester sees a grant that is then lost.
    assign grant = (state_q == StIdle) && arb_valid && !reset;

    rr_arbiter_2 u_rr (
        .clk_i    (clock),
        .rst_i    (reset),
        .req_i    ({r1_req, r0_req}),
        .grant_i  (grant),
        .winner_o (arb_winner),
        .valid_o  (arb_valid)
    );

`ifdef DATA_MEMORY_ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES < 16) ? 4 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        addr_d   = addr_q;
        din_d    = din_q;
        rd_d     = rd_q;
        macc_d   = macc_q;
        dout0_d  = dout0_q;
        dout1_d  = dout1_q;
`ifdef DATA_MEMORY_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    winner_d = arb_winner;
                    addr_d   = arb_winner ? r1_addr : r0_addr;
                    din_d    = arb_winner ? r1_din : r0_din;
                    rd_d     = arb_winner ? r1_rd : r0_rd;
                    macc_d   = 1'b1;
                    state_d  = StAccess;
`ifdef DATA_MEMORY_ARB_TIMEOUT_EN
                    cnt_d    = '0;
                    err_d    = 1'b0;
`endif
                end
            end
            StAccess: begin
                if (complete_data && macc_q) begin
                    macc_d  = 1'b0;
                    state_d = StResp;
                    if (rd_q) begin
                        if (winner_q) dout1_d = Data_dout;
                        else          dout0_d = Data_dout;
                    end
`ifdef DATA_MEMORY_ARB_TIMEOUT_EN
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    // Aborted load returns zero rather than stale data.
                    macc_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = StResp;
                    if (rd_q) begin
                        if (winner_q) dout1_d = '0;
                        else          dout0_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            winner_q <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            rd_q     <= 1'b0;
            macc_q   <= 1'b0;
            dout0_q  <= '0;
            dout1_q  <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rd_q     <= rd_d;
            macc_q   <= macc_d;
            dout0_q  <= dout0_d;
            dout1_q  <= dout1_d;
        end
    end

`ifdef DATA_MEMORY_ARB_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = (state_q == StResp) && err_q;
`else
    assign err = 1'b0;
`endif

    assign r0_gnt    = grant && !arb_winner;
    assign r1_gnt    = grant && arb_winner;
    assign r0_done   = (state_q == StResp) && !winner_q;
    assign r1_done   = (state_q == StResp) && winner_q;
    assign r0_dout   = dout0_q;
    assign r1_dout   = dout1_q;
    assign Data_addr = addr_q;
    assign Data_din  = din_q;
    assign Data_rd   = rd_q;
    assign D_macc    = macc_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: vector table, scoreboard and corner sequences.
module tb_data_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        r0_req = 1'b0, r0_rd = 1'b0, r1_req = 1'b0, r1_rd = 1'b0;
    logic [15:0] r0_addr = '0, r0_din = '0, r1_addr = '0, r1_din = '0;
    logic        r0_gnt, r0_done, r1_gnt, r1_done, err;
    logic [15:0] r0_dout, r1_dout;
    logic [15:0] Data_addr, Data_din, Data_dout = '0;
    logic        Data_rd, D_macc, complete_data = 1'b0;

    data_memory_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .r0_req        (r0_req),
        .r0_rd         (r0_rd),
        .r0_addr       (r0_addr),
        .r0_din        (r0_din),
        .r0_gnt        (r0_gnt),
        .r0_done       (r0_done),
        .r0_dout       (r0_dout),
        .r1_req        (r1_req),
        .r1_rd         (r1_rd),
        .r1_addr       (r1_addr),
        .r1_din        (r1_din),
        .r1_gnt        (r1_gnt),
        .r1_done       (r1_done),
        .r1_dout       (r1_dout),
        .err           (err),
        .Data_addr     (Data_addr),
        .Data_din      (Data_din),
        .Data_rd       (Data_rd),
        .D_macc        (D_macc),
        .complete_data (complete_data),
        .Data_dout     (Data_dout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        who;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] mem;
        int          wait_n;
        logic [15:0] exp_dout;
    } vec_t;

    typedef struct {
        logic        who;
        logic [15:0] dout;
        logic        err;
    } resp_t;

    vec_t  vecs[6];
    resp_t sb[$];
    int    n_cmp = 0;
    int    n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic who, input logic v, input logic rd,
                           input logic [15:0] addr, input logic [15:0] din);
        if (who) begin
            r1_req = v; r1_rd = rd; r1_addr = addr; r1_din = din;
        end else begin
            r0_req = v; r0_rd = rd; r0_addr = addr; r0_din = din;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        complete_data = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // Full access from one requester with the memory answering after wait_n extra cycles.
    task automatic do_access(input vec_t v);
        int    k;
        int    cyc;
        logic  got;
        resp_t r;
        @(posedge clock); #1;
        set_req(v.who, 1'b1, v.rd, v.addr, v.din);
        got = 1'b0;
        for (k = 0; k < 8; k++) begin
            @(negedge clock);
            if ((v.who ? r1_gnt : r0_gnt) === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        check("grant_latency", 64'(k), 64'd0);
        check("other_gnt_low", {63'd0, v.who ? r0_gnt : r1_gnt}, 64'd0);
        if (!got) begin
            set_req(v.who, 1'b0, 1'b0, '0, '0);
            return;
        end
        sb.push_back('{who: v.who, dout: v.exp_dout, err: 1'b0});
        @(posedge clock); #1;
        set_req(v.who, 1'b0, 1'b0, 16'hDEAD, 16'hDEAD);
        Data_dout = v.mem;
        complete_data = (v.wait_n == 0);
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clock);
            check("bus_hold", {29'd0, D_macc, Data_rd, r0_done | r1_done, Data_addr, Data_din},
                  {29'd0, 1'b1, v.rd, 1'b0, v.addr, v.din});
            if (complete_data) break;
            @(posedge clock); #1;
            complete_data = (cyc + 1 == v.wait_n);
        end
        check("macc_cycles", 64'(cyc), 64'(v.wait_n));
        @(posedge clock); #1;
        complete_data = 1'b0;
        Data_dout = 16'h0BAD;
        @(negedge clock);
        check("macc_cleared", {63'd0, D_macc}, 64'd0);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            r = sb.pop_front();
            check("done_pulse", {62'd0, r1_done, r0_done}, r.who ? 64'd2 : 64'd1);
            check("dout", {48'd0, r.who ? r1_dout : r0_dout}, {48'd0, r.dout});
            check("err_low", {63'd0, err}, {63'd0, r.err});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        vecs[0] = '{who: 1'b0, rd: 1'b1, addr: 16'h3000, din: 16'h0000, mem: 16'hBEEF,
                    wait_n: 2, exp_dout: 16'hBEEF};
        vecs[1] = '{who: 1'b1, rd: 1'b0, addr: 16'h4010, din: 16'h1234, mem: 16'h9999,
                    wait_n: 1, exp_dout: 16'h0000};
        vecs[2] = '{who: 1'b1, rd: 1'b1, addr: 16'h4010, din: 16'h0000, mem: 16'h1234,
                    wait_n: 0, exp_dout: 16'h1234};
        vecs[3] = '{who: 1'b0, rd: 1'b0, addr: 16'h3001, din: 16'h5555, mem: 16'h6666,
                    wait_n: 3, exp_dout: 16'hBEEF};
        vecs[4] = '{who: 1'b1, rd: 1'b0, addr: 16'h0000, din: 16'hFFFF, mem: 16'h7777,
                    wait_n: 0, exp_dout: 16'h1234};
        vecs[5] = '{who: 1'b0, rd: 1'b1, addr: 16'hFFFF, din: 16'h0000, mem: 16'hA5A5,
                    wait_n: 0, exp_dout: 16'hA5A5};

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_state", {27'd0, D_macc, Data_rd, r0_gnt, r1_gnt, r0_done, r1_done, err,
                              r0_dout, r1_dout}, 64'd0);

        for (int i = 0; i < 6; i++) do_access(vecs[i]);

        // Reset in the middle of an access drops it silently.
        @(posedge clock); #1;
        set_req(1'b0, 1'b1, 1'b1, 16'h3100, 16'h0000);
        @(negedge clock);
        check("rst_test_gnt", {63'd0, r0_gnt}, 64'd1);
        @(posedge clock); #1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        @(negedge clock);
        check("rst_test_macc_before", {63'd0, D_macc}, 64'd1);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_clears", {14'd0, D_macc, Data_rd, Data_addr, r0_dout, r1_dout}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("rst_no_done", {62'd0, r0_done, r1_done}, 64'd0);
        end
        do_access('{who: 1'b1, rd: 1'b1, addr: 16'h2222, din: 16'h0, mem: 16'hC0DE,
                    wait_n: 1, exp_dout: 16'hC0DE});

        // Both requesting continuously with zero-wait memory: alternate every 3 cycles.
        pulse_reset();
        set_req(1'b0, 1'b1, 1'b1, 16'h1000, 16'h0000);
        set_req(1'b1, 1'b1, 1'b1, 16'h2000, 16'h0000);
        Data_dout = 16'h00AA;
        for (int c = 0; c < 12; c++) begin
            complete_data = D_macc;
            @(negedge clock);
            check("rr_grants", {62'd0, r1_gnt, r0_gnt},
                  (c % 6 == 0) ? 64'd1 : (c % 6 == 3) ? 64'd2 : 64'd0);
            if (c % 3 == 1)
                check("rr_addr", {48'd0, Data_addr}, (c % 6 == 1) ? 64'h1000 : 64'h2000);
            @(posedge clock); #1;
        end
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        complete_data = 1'b0;
        @(negedge clock);
        check("rr_douts", {32'd0, r0_dout, r1_dout}, 64'h00AA00AA);

        // Memory that never completes.
        pulse_reset();
        do_access('{who: 1'b1, rd: 1'b1, addr: 16'h5000, din: 16'h0, mem: 16'h7777,
                    wait_n: 1, exp_dout: 16'h7777});
        @(posedge clock); #1;
        set_req(1'b1, 1'b1, 1'b1, 16'h5002, 16'h0000);
        @(negedge clock);
        check("to_gnt", {63'd0, r1_gnt}, 64'd1);
        @(posedge clock); #1;
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (!D_macc) break;
            cnt++;
            @(posedge clock); #1;
        end
`ifdef DATA_MEMORY_ARB_TIMEOUT_EN
        check("to_cycles", 64'(cnt), 64'd15);
        check("to_resp", {45'd0, r1_done, err, r1_dout}, {45'd0, 1'b1, 1'b1, 16'h0000});
`else
        check("to_macc_held", 64'(cnt), 64'd30);
        check("to_no_done", {61'd0, r0_done, r1_done, err}, 64'd0);
        check("to_dout_kept", {48'd0, r1_dout}, 64'h7777);
`endif
        pulse_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
